// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_DFLT   = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch stage and memory.
interface fetch_unit_if;

  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ready;
  logic        in_imem_valid;
  logic [31:0] in_imem_data;

  modport master (
    output out_imem_req,
    output out_imem_addr,
    input  in_imem_ready,
    input  in_imem_valid,
    input  in_imem_data
  );

  modport slave (
    input  out_imem_req,
    input  out_imem_addr,
    output in_imem_ready,
    output in_imem_valid,
    output in_imem_data
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, skid slot for stalled delivery,
// redirect flushes the output and kills any wrong-path response in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [31:0] BUBBLE   = BUBBLE_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_stall,
  input  logic                in_redirect,
  input  logic [31:0]         in_redirect_PC,
  fetch_unit_if.master        imem,
  output logic [31:0]         out_instruction,
  output logic [31:0]         out_PC,
  output logic                out_valid
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_kill;
  logic [31:0]  r_skid_instr;
  logic [31:0]  r_skid_pc;
  logic [31:0]  r_out_instr;
  logic [31:0]  r_out_pc;
  logic         r_out_valid;

  logic w_accept;
  logic w_resp;
  logic w_slot_free;

  assign imem.out_imem_req  = (r_state == REQ) && !reset;
  assign imem.out_imem_addr = r_pc;

  assign w_accept    = (r_state == REQ) && imem.in_imem_ready;
  assign w_resp      = (r_state == WAIT) && imem.in_imem_valid;
  // The slot can take a new instruction unless it holds one IF/ID is not consuming.
  assign w_slot_free = !r_out_valid || !in_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid_instr <= BUBBLE;
      r_skid_pc    <= '0;
      r_out_instr  <= BUBBLE;
      r_out_pc     <= '0;
      r_out_valid  <= 1'b0;
    end else if (in_redirect) begin
      r_pc         <= in_redirect_PC;
      r_out_instr  <= BUBBLE;
      r_out_pc     <= '0;
      r_out_valid  <= 1'b0;
      r_skid_instr <= BUBBLE;
      r_skid_pc    <= '0;
      r_state      <= REQ;
      r_kill       <= 1'b0;
      // A request still in flight after this edge belongs to the wrong path.
      if (w_accept || ((r_state == WAIT) && !imem.in_imem_valid)) begin
        r_kill  <= 1'b1;
        r_state <= WAIT;
      end
    end else begin
      if (!in_stall) begin
        r_out_instr <= BUBBLE;
        r_out_pc    <= '0;
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        REQ: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_INC;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (w_resp) begin
            r_kill  <= 1'b0;
            r_state <= REQ;
            if (!r_kill) begin
              if (w_slot_free) begin
                r_out_instr <= imem.in_imem_data;
                r_out_pc    <= r_req_pc;
                r_out_valid <= 1'b1;
              end else begin
                r_skid_instr <= imem.in_imem_data;
                r_skid_pc    <= r_req_pc;
                r_state      <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!in_stall) begin
            r_out_instr  <= r_skid_instr;
            r_out_pc     <= r_skid_pc;
            r_out_valid  <= 1'b1;
            r_skid_instr <= BUBBLE;
            r_skid_pc    <= '0;
            r_state      <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign out_instruction = r_out_instr;
  assign out_PC          = r_out_pc;
  assign out_valid       = r_out_valid;

endmodule
